// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, RGB332 colours and paddle motion direction.
package pong_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_GREEN = 8'h1C;
    localparam logic [7:0] RGB_BLUE  = 8'h03;

    typedef enum logic [1:0] {
        DirIdle = 2'd0,
        DirUp   = 2'd1,
        DirDown = 2'd2
    } dir_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous active-low button; resets to released (1).
module btn_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], async_i};
        end
    end

    assign sync_o = ff_q[1];

endmodule

// File: rtl/paddle_renderer.sv
// Button-driven paddle with tick-paced, optionally accelerating motion and a registered
// pixel renderer.
module paddle_renderer
    import pong_pkg::*;
#(
    parameter int unsigned X_LEFT     = 560,
    parameter int unsigned PAD_W      = 10,
    parameter int unsigned PAD_H      = 100,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned INIT_Y     = 190,
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned STEP_MIN   = 3,
    parameter int unsigned STEP_MAX   = 9,
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned ACCEL      = 1,
    parameter logic [7:0]  COLOR      = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       enable,
    input  logic       inp_down_n,
    input  logic       inp_up_n,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       layer,
    output logic [9:0] pad_y
);

    localparam int unsigned Y_MAX  = V_ACTIVE - PAD_H;
    localparam int unsigned CntW   = $clog2(TICK_DIV + 1);
    localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);
    localparam int unsigned SpdTop = (STEP_MAX > STEP_MIN) ? STEP_MAX : STEP_MIN;
    localparam int unsigned SpdW   = $clog2(SpdTop + 1);

    localparam logic [CntW-1:0]  CntReload = CntW'(TICK_DIV - 1);
    localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_TICKS - 1);
    localparam logic [SpdW-1:0]  SpdMin    = SpdW'(STEP_MIN);
    localparam logic [SpdW-1:0]  SpdMax    = SpdW'(STEP_MAX);

    logic down_sync, up_sync;

    btn_sync u_sync_down (
        .clock   (clock),
        .reset   (reset),
        .async_i (inp_down_n),
        .sync_o  (down_sync)
    );

    btn_sync u_sync_up (
        .clock   (clock),
        .reset   (reset),
        .async_i (inp_up_n),
        .sync_o  (up_sync)
    );

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [9:0]       pad_y_q, pad_y_d;
    logic [SpdW-1:0]  speed_q, speed_d;
    logic [HoldW-1:0] hold_q, hold_d;
    dir_e             prev_q, prev_d;
    logic [7:0]       pix_q, pix_d;
    logic             layer_q, layer_d;

    logic            tick;
    logic            reversal;
    dir_e            dir;
    logic [SpdW-1:0] step;
    logic [10:0]     sum;
    logic            h_in, v_in;

    always_comb begin
        dir = DirIdle;
        if (!down_sync && up_sync) begin
            dir = DirDown;
        end else if (down_sync && !up_sync) begin
            dir = DirUp;
        end

        tick     = (cnt_q == '0);
        cnt_d    = tick ? CntReload : cnt_q - 1'b1;
        // Only an UP<->DOWN flip counts as a change; starting from idle keeps counting.
        reversal = ((prev_q == DirUp) && (dir == DirDown)) ||
                   ((prev_q == DirDown) && (dir == DirUp));

        pad_y_d = pad_y_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        prev_d  = prev_q;
        step    = speed_q;

        if (tick) begin
            prev_d = dir;
            if (dir == DirIdle) begin
                speed_d = SpdMin;
                hold_d  = '0;
            end else if (reversal) begin
                step    = SpdMin;
                speed_d = SpdMin;
                hold_d  = '0;
            end else if (ACCEL != 0) begin
                if (hold_q == HoldLast) begin
                    hold_d = '0;
                    if (speed_q < SpdMax) begin
                        speed_d = speed_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end

        sum = {1'b0, pad_y_q} + 11'(step);
        if (tick && (dir == DirDown)) begin
            pad_y_d = (sum > 11'(Y_MAX)) ? 10'(Y_MAX) : sum[9:0];
        end else if (tick && (dir == DirUp)) begin
            pad_y_d = (pad_y_q < 10'(step)) ? 10'd0 : pad_y_q - 10'(step);
        end

        // Hit test deliberately uses the current register, not this cycle's update.
        h_in = ({1'b0, hcount} >= 11'(X_LEFT)) && ({1'b0, hcount} < 11'(X_LEFT + PAD_W));
        v_in = (vcount >= pad_y_q) && ({1'b0, vcount} < ({1'b0, pad_y_q} + 11'(PAD_H)));

        layer_d = enable && h_in && v_in;
        pix_d   = layer_d ? COLOR : RGB_BLACK;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= CntReload;
            pad_y_q <= 10'(INIT_Y);
            speed_q <= SpdMin;
            hold_q  <= '0;
            prev_q  <= DirIdle;
            pix_q   <= RGB_BLACK;
            layer_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pad_y_q <= pad_y_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
            prev_q  <= prev_d;
            pix_q   <= pix_d;
            layer_q <= layer_d;
        end
    end

    assign red   = pix_q[7:5];
    assign green = pix_q[4:2];
    assign blue  = pix_q[1:0];
    assign layer = layer_q;
    assign pad_y = pad_y_q;

endmodule

// File: doc/paddle_renderer.md
PADDLE_RENDERER -- requirements
Module: paddle_renderer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_LEFT, 560: paddle left column (pixels).
- PAD_W, 10: paddle width (pixels).
- PAD_H, 100: paddle height (pixels).
- V_ACTIVE, 480: visible lines.
- INIT_Y, 190: paddle top row after reset.
- TICK_DIV, 5_000_000: clock cycles per motion tick.
- STEP_MIN, 3: base step (pixels per tick).
- STEP_MAX, 9: maximum step when ACCEL=1.
- HOLD_TICKS, 4: ticks of continuous hold per step increment.
- ACCEL, 1: 1 enables acceleration; 0 keeps a fixed STEP_MIN step.
- COLOR, 8'hFF: paddle colour {red[2:0], green[2:0], blue[1:0]}.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1: the block's one clock.
- reset, in, 1: synchronous, active-high reset.
- hcount, in, 10: current pixel column.
- vcount, in, 10: current pixel row.
- enable, in, 1: active-video qualifier.
- inp_down_n, in, 1: active-low button; asynchronous input that increases Y.
- inp_up_n, in, 1: active-low button; asynchronous input that decreases Y.
- red, out, 3: red pixel value.
- green, out, 3: green pixel value.
- blue, out, 2: blue pixel value.
- layer, out, 1: 1 when the paddle pixel is drawn.
- pad_y, out, 10: current paddle top row, used for ball collision.

Function
REQ-003 Each button input SHALL pass through a two-flop synchronizer before use; synchronized outputs reset to 1 (released).
REQ-004 The tick counter SHALL reload to TICK_DIV-1 and decrement once per cycle; tick SHALL pulse for one cycle when the counter is 0.
REQ-005 Motion SHALL be evaluated only on a tick cycle.
REQ-006 Direction each tick: down only -> DOWN; up only -> UP; both pressed or neither -> IDLE.
REQ-007 DOWN SHALL set pad_y to min(pad_y+speed, Y_MAX), where Y_MAX = V_ACTIVE-PAD_H; the sum SHALL be computed 11 bits wide, with no wrap.
REQ-008 UP SHALL set pad_y to 0 if pad_y < speed, else pad_y-speed; pad_y SHALL never underflow.
REQ-009 IDLE SHALL hold pad_y, set speed to STEP_MIN and set hold_cnt to 0.
REQ-010 With ACCEL=1, a tick in the same direction as the previous tick SHALL increment hold_cnt.
REQ-011 With ACCEL=1, when hold_cnt reaches HOLD_TICKS-1: hold_cnt SHALL become 0, and speed SHALL increment by 1 if speed < STEP_MAX.
REQ-012 With ACCEL=1, a direction change SHALL set speed to STEP_MIN and hold_cnt to 0, and the move on that tick SHALL use STEP_MIN.
REQ-013 With ACCEL=0, speed SHALL remain STEP_MIN.
REQ-014 The new speed SHALL take effect on the next tick.
REQ-015 Hit test: X_LEFT <= hcount < X_LEFT+PAD_W and pad_y <= vcount < pad_y+PAD_H.
REQ-016 The pixel outputs SHALL be registered with 1-cycle latency.
REQ-017 enable=1 and hit -> {red,green,blue}=COLOR and layer=1.
REQ-018 Otherwise -> RGB=0 and layer=0.
REQ-019 The hit test SHALL use the pad_y value registered before any same-cycle update.
REQ-020 pad_y output SHALL equal the internal position register (no extra latency).

Reset
REQ-021 On reset=1 at a clock edge, the following SHALL be set:
- pad_y=INIT_Y.
- speed=STEP_MIN.
- hold_cnt=0.
- previous direction=IDLE.
- tick counter=TICK_DIV-1.
- synchronizers=1.
- red/green/blue=0 and layer=0.
REQ-022 Reset SHALL override tick, buttons and enable in the same cycle.
REQ-023 Reset mid-motion SHALL discard any pending step.

Structure
REQ-024 Shared package pong_pkg SHALL hold:
- screen constants H_ACTIVE=640 and V_ACTIVE=480.
- RGB332 colour constants.
- the direction enum (IDLE/UP/DOWN).
REQ-025 Sub-module btn_sync (two-flop synchronizer, reset value 1) SHALL be instantiated once per button.
REQ-026 The block SHALL contain no combinational path from the inputs to the outputs other than through pad_y.

Verification
REQ-027 Bench parameters TICK_DIV=4, INIT_Y=190, ACCEL=0: hold inp_down_n=0 for 3 ticks -> pad_y 190->193->196->199.
REQ-028 Saturation, ACCEL=0: pad_y=378, hold down -> 380 then stays 380. pad_y=2, hold up -> 0 then stays 0, never 1023.
REQ-029 ACCEL=1, HOLD_TICKS=2, STEP_MAX=5, start 100, hold down 8 ticks -> 103,106,110,114,119,124,129,134. Reverse to up -> next pad_y 131.
REQ-030 Both buttons pressed for 5 ticks -> pad_y unchanged and speed=STEP_MIN.
REQ-031 Pixel test, pad_y=190, enable=1:
- (hcount,vcount)=(560,190) -> RGB=8'hFF and layer=1, one cycle later.
- (570,190) and (565,290) -> 0.
- same inputs with enable=0 -> 0.
REQ-032 Assert reset during a held-down sequence at pad_y=250 -> next cycle pad_y=190, outputs 0, and the first move occurs TICK_DIV cycles after release.
